// File: rtl/adc733_cfg_ctrl_if.sv
// Host register bus and control-word handshake toward the ADC733 serial-port core.
// The controller takes the slave view; the host / serial-core side takes the master view.
interface adc733_cfg_ctrl_if;
  logic        host_wr;
  logic [2:0]  host_addr;
  logic [7:0]  host_data;
  logic        host_rej;
  logic        cfg_start;
  logic        cw_valid;
  logic [15:0] cw_data;
  logic        cw_ready;
  logic        word_sent;

  modport slave (
    input  host_wr, host_addr, host_data, cfg_start, cw_ready, word_sent,
    output host_rej, cw_valid, cw_data
  );

  modport master (
    output host_wr, host_addr, host_data, cfg_start, cw_ready, word_sent,
    input  host_rej, cw_valid, cw_data
  );
endinterface

// File: rtl/adc733_cfg_ctrl.sv
// ADC733 configuration controller: programs CRA..CRH from a host-writable shadow file through
// the serial core's valid/ready control-word port, then sends the data-mode entry word.
// Optional build macro: ADC733_CFG_TIMEOUT_EN adds a word_sent watchdog that drives cfg_err.
module adc733_cfg_ctrl #(
  parameter logic [2:0]  DEV_ADDR    = 3'd0,
  parameter logic [7:0]  DMODE_DATA  = 8'h01,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  adc733_cfg_ctrl_if.slave        bus,
  output logic                    busy,
  output logic                    cfg_done,
  output logic [2:0]              cur_reg,
  output logic                    cfg_err
);

  typedef enum logic [3:0] {
    StIdle, StLoad, StSend, StWait, StDload, StDsend, StDwait, StRun, StErr
  } state_e;

  localparam logic [15:0] DmodeWord = {1'b1, 1'b1, 3'd0, DEV_ADDR, DMODE_DATA};

  state_e      state_q;
  logic [2:0]  idx_q;
  logic        cw_valid_q;
  logic [15:0] cw_data_q;
  logic        cfg_done_q;
  logic        host_rej_q;
  logic [7:0]  shadow_q [8];
  logic [15:0] prog_word;

  assign busy         = !(state_q inside {StIdle, StRun, StErr});
  assign cur_reg      = idx_q;
  assign cfg_done     = cfg_done_q;
  assign bus.cw_valid = cw_valid_q;
  assign bus.cw_data  = cw_data_q;
  assign bus.host_rej = host_rej_q;
  assign prog_word    = {1'b0, 1'b1, idx_q, DEV_ADDR, shadow_q[idx_q]};

`ifdef ADC733_CFG_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  // Terminal count is checked one cycle early so the move to ERR lands as the count reaches
  // TIMEOUT_CYC.
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  logic [TmoW-1:0] tmo_q;
  logic            cfg_err_q;

  assign cfg_err = cfg_err_q;
`else
  // TIMEOUT_CYC only matters when the watchdog is built in.
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign cfg_err = 1'b0;
`endif

  // Shadow file: host writes land only while no sequence is active; dropped writes pulse host_rej.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rej_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= 8'h00;
      end
    end else begin
      host_rej_q <= bus.host_wr & busy;
      if (bus.host_wr && !busy) begin
        shadow_q[bus.host_addr] <= bus.host_data;
      end
    end
  end

  // Sequencer: eight program words, then the data-mode word, each as load / handshake / wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= 3'd0;
      cw_valid_q <= 1'b0;
      cw_data_q  <= 16'h0000;
      cfg_done_q <= 1'b0;
`ifdef ADC733_CFG_TIMEOUT_EN
      tmo_q      <= '0;
      cfg_err_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StRun, StErr: begin
          if (bus.cfg_start) begin
            cfg_done_q <= 1'b0;
`ifdef ADC733_CFG_TIMEOUT_EN
            cfg_err_q  <= 1'b0;
`endif
            idx_q      <= 3'd0;
            state_q    <= StLoad;
          end
        end
        StLoad: begin
          // Shadow data is snapshotted here and held until the core accepts it.
          cw_data_q  <= prog_word;
          cw_valid_q <= 1'b1;
          state_q    <= StSend;
        end
        StSend, StDsend: begin
          // A word_sent seen here cannot belong to the unaccepted word, so it is ignored.
          if (bus.cw_ready) begin
            cw_valid_q <= 1'b0;
            state_q    <= (state_q == StSend) ? StWait : StDwait;
`ifdef ADC733_CFG_TIMEOUT_EN
            tmo_q      <= '0;
`endif
          end
        end
        StWait, StDwait: begin
          if (bus.word_sent) begin
            if (state_q == StDwait) begin
              cfg_done_q <= 1'b1;
              state_q    <= StRun;
            end else if (idx_q == 3'd7) begin
              state_q <= StDload;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= StLoad;
            end
          end
`ifdef ADC733_CFG_TIMEOUT_EN
          else if (tmo_q == TmoLast) begin
            cfg_err_q <= 1'b1;
            state_q   <= StErr;
          end
          tmo_q <= tmo_q + 1'b1;
`endif
        end
        StDload: begin
          // The data-mode word gets its own load cycle, like every program word.
          cw_data_q  <= DmodeWord;
          cw_valid_q <= 1'b1;
          state_q    <= StDsend;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_adc733_cfg_ctrl.sv
// Self-checking bench for adc733_cfg_ctrl: a transaction-level scoreboard checks every cycle,
// directed sequences pin the model with hand-computed words and latencies.
module tb_adc733_cfg_ctrl;
`ifdef ADC733_CFG_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 4096;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy, cfg_done, cfg_err;
  logic [2:0] cur_reg;

  adc733_cfg_ctrl_if bus ();

  adc733_cfg_ctrl #(
    .DEV_ADDR    (3'd0),
    .DMODE_DATA  (8'h01),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .cfg_done (cfg_done),
    .cur_reg  (cur_reg),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard model ----------------
  logic [7:0]  m_shadow [8];
  logic        m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, m_rej = 1'b0, m_pend = 1'b0;
  int          m_sent = 0, m_wcnt = 0, stall_seen = 0;
  logic [15:0] expq [$];
  logic [15:0] cap [$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = 16'h0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_cw_valid", bus.cw_valid, 0);
        chk("rst_cw_data", bus.cw_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_done", cfg_done, 0);
        chk("rst_host_rej", bus.host_rej, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_cur_reg", cur_reg, 0);
        for (int i = 0; i < 8; i++) m_shadow[i] = 8'h00;
        m_busy = 0; m_done = 0; m_err = 0; m_rej = 0; m_pend = 0; m_sent = 0;
        expq.delete();
        prev_stall = 0;
      end else begin
        chk("busy", busy, m_busy);
        chk("cfg_done", cfg_done, m_done);
        chk("host_rej", bus.host_rej, m_rej);
        chk("cfg_err", cfg_err, m_err);
        chk("cur_reg", cur_reg, (m_sent > 7) ? 7 : m_sent);
        if (!m_busy) chk("idle_cw_valid", bus.cw_valid, 0);
        if (prev_stall) begin
          chk("hold_cw_valid", bus.cw_valid, 1);
          chk("hold_cw_data", bus.cw_data, prev_data);
        end
        // Advance the model with this cycle's inputs.
        m_rej = bus.host_wr && m_busy;
        if (bus.host_wr && !m_busy) m_shadow[bus.host_addr] = bus.host_data;
        if (bus.cfg_start && !m_busy) begin
          m_busy = 1; m_done = 0; m_err = 0; m_sent = 0; m_pend = 0;
          expq.delete();
          cap.delete();
          for (int i = 0; i < 8; i++) begin
            logic [2:0] ii;
            ii = 3'(i);
            expq.push_back({2'b01, ii, 3'd0, m_shadow[i]});
          end
          expq.push_back(16'hC001);
        end else if (m_busy) begin
          if (bus.cw_valid && bus.cw_ready) begin
            if (expq.size() == 0) chk("extra_word", bus.cw_data, 16'hxxxx);
            else chk("word", bus.cw_data, expq.pop_front());
            cap.push_back(bus.cw_data);
            m_pend = 1;
            m_wcnt = 0;
          end else if (m_pend) begin
            if (bus.word_sent) begin
              m_pend = 0;
              m_sent++;
              if (m_sent == 9) begin
                m_busy = 0;
                m_done = 1;
              end
            end else begin
              m_wcnt++;
`ifdef ADC733_CFG_TIMEOUT_EN
              if (m_wcnt == int'(TMO)) begin
                m_busy = 0; m_err = 1; m_pend = 0;
                expq.delete();
              end
`endif
            end
          end
        end
        prev_stall = bus.cw_valid && !bus.cw_ready;
        prev_data  = bus.cw_data;
        if (prev_stall && bus.cw_data == 16'h5012) stall_seen++;
      end
    end
  end

  // ---------------- serial-core stand-in ----------------
  int ws_skip_idx = -1;
  int stall_idx = -1;
  int stall_left = 0;

  initial begin
    bus.word_sent = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.cw_valid && bus.cw_ready && int'(cur_reg) != ws_skip_idx) begin
        @(posedge clk); #1 bus.word_sent = 1'b1;
        @(posedge clk); #1 bus.word_sent = 1'b0;
      end
    end
  end

  initial begin
    bus.cw_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0 && bus.cw_valid && int'(cur_reg) == stall_idx) begin
        bus.cw_ready = 1'b0;
        stall_left--;
      end else begin
        bus.cw_ready = 1'b1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    bus.host_wr = 1'b1; bus.host_addr = a; bus.host_data = d;
    tick();
    bus.host_wr = 1'b0;
  endtask

  task automatic pulse_start();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!cfg_done && n < 400) begin
      tick();
      n++;
    end
    if (!cfg_done) chk({nm, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_reg(input string nm, input int r, input logic valid);
    int n = 0;
    while (!(int'(cur_reg) == r && bus.cw_valid == valid) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk({nm, "_wait_timeout"}, 0, 1);
  endtask

  initial begin
    int t0;
    bus.host_wr = 0; bus.host_addr = 0; bus.host_data = 0; bus.cfg_start = 0;
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    // Sequence 1: CRA..CRH = 10..17, last write shares the cycle with cfg_start.
    for (int i = 0; i < 7; i++) host_write(3'(i), 8'(8'h10 + i));
    bus.host_wr = 1'b1; bus.host_addr = 3'd7; bus.host_data = 8'h17; bus.cfg_start = 1'b1;
    t0 = cyc;
    tick();
    bus.host_wr = 1'b0; bus.cfg_start = 1'b0;
    wait_done("seq1");
    chk("seq1_latency", cyc - t0, 28);
    chk("seq1_busy_at_done", busy, 0);
    chk("seq1_len", cap.size(), 9);
    if (cap.size() >= 9) begin
      chk("seq1_w0", cap[0], 16'h4010);
      chk("seq1_w1", cap[1], 16'h4811);
      chk("seq1_w7", cap[7], 16'h7817);
      chk("seq1_w8", cap[8], 16'hC001);
    end
    tick(); tick();

    // Sequence 2: rewrite CRB in RUN, restart, stall word 2, rejected write during word 1.
    host_write(3'd1, 8'h08);
    stall_idx = 2; stall_left = 5; stall_seen = 0;
    pulse_start();
    chk("seq2_done_drop", cfg_done, 0);
    wait_reg("seq2_w1", 1, 1'b1);
    host_write(3'd3, 8'hAA);
    chk("seq2_rej_pulse", bus.host_rej, 1);
    tick();
    chk("seq2_rej_once", bus.host_rej, 0);
    wait_done("seq2");
    chk("seq2_len", cap.size(), 9);
    chk("seq2_stall_cycles", stall_seen, 5);
    if (cap.size() >= 9) begin
      chk("seq2_w1", cap[1], 16'h4808);
      chk("seq2_w2", cap[2], 16'h5012);
      chk("seq2_w3", cap[3], 16'h5813);
    end
    tick();

    // Sequence 3: reset while waiting for word_sent of word 5.
    pulse_start();
    wait_reg("seq3_w5_send", 5, 1'b1);
    wait_reg("seq3_w5_wait", 5, 1'b0);
    rst = 1'b1;
    tick();
    chk("seq3_rst_valid", bus.cw_valid, 0);
    chk("seq3_rst_data", bus.cw_data, 0);
    chk("seq3_rst_busy", busy, 0);
    chk("seq3_rst_cur", cur_reg, 0);
    rst = 1'b0;
    tick();

    // Sequence 4: full run after reset, shadow back to zero.
    pulse_start();
    wait_done("seq4");
    chk("seq4_len", cap.size(), 9);
    if (cap.size() >= 9) begin
      chk("seq4_w0", cap[0], 16'h4000);
      chk("seq4_w7", cap[7], 16'h7800);
      chk("seq4_w8", cap[8], 16'hC001);
    end
    tick();

`ifdef ADC733_CFG_TIMEOUT_EN
    // Sequence 5: word_sent withheld for word 3, watchdog trips, restart clears the error.
    begin
      int ta = 0;
      int n = 0;
      ws_skip_idx = 3;
      pulse_start();
      wait_reg("seq5_w3", 3, 1'b1);
      ta = cyc + 1;
      while (!cfg_err && n < 100) begin
        tick();
        n++;
      end
      chk("seq5_err", cfg_err, 1);
      chk("seq5_err_latency", cyc - ta, 16);
      chk("seq5_err_busy", busy, 0);
      chk("seq5_err_valid", bus.cw_valid, 0);
      ws_skip_idx = -1;
      tick();
      pulse_start();
      chk("seq5_err_clear", cfg_err, 0);
      wait_done("seq5");
      chk("seq5_len", cap.size(), 9);
    end
`endif

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
